bsg_tiehi_release_seq: RTL and testbench

- Sequencer for a bank of tie-high control lines, such as isolation, clamp or hold enables, that must be driven to 1 while the chip powers up.
- Comes out of reset with every output held at 1.
- On a start request, releases the outputs to 0 one bit at a time, LSB first, with a fixed programmable gap between releases.
- Sits between the reset/power controller and the tie-high-protected logic; can re-tie the whole bank at any time.

---
 rtl/bsg_tiehi_release_seq.sv | 95 +++++++++
 tb/tb_bsg_tiehi_release_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_tiehi_release_seq.sv
// Releases a bank of tie-high lines LSB first with a fixed gap between releases.
// A relock or reset re-ties the entire bank to 1.
module bsg_tiehi_release_seq #(
  parameter int width_p      = 16,
  parameter int gap_cycles_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               hold_i,
  input  logic               relock_i,
  output logic               ready_o,
  output logic [width_p-1:0] o,
  output logic               done_o
);

  localparam int cnt_w_lp = (gap_cycles_p > 1) ? $clog2(gap_cycles_p) : 1;
  localparam int idx_w_lp = (width_p > 1) ? $clog2(width_p) : 1;
  localparam logic [cnt_w_lp-1:0] gap_reload_lp = cnt_w_lp'(gap_cycles_p - 1);
  localparam logic [idx_w_lp-1:0] idx_last_lp   = idx_w_lp'(width_p - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e              state_r, state_n;
  logic [cnt_w_lp-1:0] cnt_r, cnt_n;
  logic [idx_w_lp-1:0] idx_r, idx_n;
  logic [width_p-1:0]  o_r, o_n;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      o_r     <= '1;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      o_r     <= o_n;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    o_n     = o_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_n = RUN;
          cnt_n   = gap_reload_lp;
          idx_n   = '0;
        end
      end
      RUN: begin
        if (!hold_i) begin
          if (cnt_r != '0) begin
            cnt_n = cnt_r - cnt_w_lp'(1);
          end else begin
            o_n   = o_r & ~(width_p'(1) << idx_r);
            cnt_n = gap_reload_lp;
            if (idx_r == idx_last_lp) begin
              state_n = DONE;
            end else begin
              idx_n = idx_r + idx_w_lp'(1);
            end
          end
        end
      end
      DONE: begin
        o_n = '0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // Relock overrides everything, including a release due on this same edge.
    if (relock_i) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
      o_n     = '1;
    end
  end

  assign o       = o_r;
  assign ready_o = (state_r == IDLE);
  assign done_o  = (state_r == DONE);

endmodule

// File: tb/tb_bsg_tiehi_release_seq.sv
// Bench for bsg_tiehi_release_seq: a default instance and a width 1 / gap 1 instance
// share the same inputs and are both compared against an elapsed-cycle model.
module tb_bsg_tiehi_release_seq;

  localparam int WA = 16;
  localparam int GA = 4;
  localparam int WB = 1;
  localparam int GB = 1;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic          hold_i = 1'b0;
  logic          relock_i = 1'b0;
  logic          ready_a, done_a, ready_b, done_b;
  logic [WA-1:0] o_a;
  logic [WB-1:0] o_b;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  // The model tracks only "active or not" and how many un-held edges have passed since start.
  int m_mode[2] = '{0, 0};
  int m_n[2] = '{0, 0};

  bsg_tiehi_release_seq #(.width_p(WA), .gap_cycles_p(GA)) dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .hold_i(hold_i),
    .relock_i(relock_i), .ready_o(ready_a), .o(o_a), .done_o(done_a)
  );

  bsg_tiehi_release_seq #(.width_p(WB), .gap_cycles_p(GB)) dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .hold_i(hold_i),
    .relock_i(relock_i), .ready_o(ready_b), .o(o_b), .done_o(done_b)
  );

  always #5 clk_i = ~clk_i;

  function automatic int w_of(input int k);
    return (k == 0) ? WA : WB;
  endfunction

  function automatic int g_of(input int k);
    return (k == 0) ? GA : GB;
  endfunction

  function automatic int released(input int k);
    int r;
    r = m_n[k] / g_of(k);
    if (r > w_of(k)) r = w_of(k);
    return r;
  endfunction

  function automatic int exp_o(input int k);
    longint v;
    v = (64'hFFFF_FFFF << released(k)) & ((64'd1 << w_of(k)) - 64'd1);
    return int'(v);
  endfunction

  function automatic int exp_done(input int k);
    return (m_mode[k] == 1 && released(k) == w_of(k)) ? 1 : 0;
  endfunction

  function automatic int exp_ready(input int k);
    return (m_mode[k] == 0) ? 1 : 0;
  endfunction

  always @(posedge clk_i or posedge reset_i) begin
    for (int k = 0; k < 2; k++) begin
      if (reset_i) begin
        m_mode[k] = 0;
        m_n[k] = 0;
      end else if (relock_i) begin
        m_mode[k] = 0;
        m_n[k] = 0;
      end else if (m_mode[k] == 0) begin
        if (start_i) begin
          m_mode[k] = 1;
          m_n[k] = 0;
        end
      end else if (!hold_i && m_n[k] < w_of(k) * g_of(k)) begin
        m_n[k] = m_n[k] + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk_i) begin
    if (checking) begin
      checkOutput("model o_a", int'(o_a), exp_o(0));
      checkOutput("model done_a", int'(done_a), exp_done(0));
      checkOutput("model ready_a", int'(ready_a), exp_ready(0));
      checkOutput("model o_b", int'(o_b), exp_o(1));
      checkOutput("model done_b", int'(done_b), exp_done(1));
      checkOutput("model ready_b", int'(ready_b), exp_ready(1));
    end
  end

  // Each call spans exactly one rising edge; outputs are read after the following falling edge.
  task automatic applyStimulus(input logic s, input logic h, input logic r);
    start_i = s;
    hold_i = h;
    relock_i = r;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk_i);
    checking = 1'b1;
    idle(2);
    reset_i = 1'b0;

    // Idle after reset: everything tied.
    for (int i = 0; i < 10; i++) begin
      idle(1);
      checkOutput("idle o", int'(o_a), 32'hFFFF);
      checkOutput("idle ready", int'(ready_a), 1);
    end

    // Plain run with default timing.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      idle(1);
      if (k == 1) checkOutput("run ready low", int'(ready_a), 0);
      if (k == 3) checkOutput("run E0+3", int'(o_a), 32'hFFFF);
      if (k == 4) checkOutput("run E0+4", int'(o_a), 32'hFFFE);
      if (k == 8) checkOutput("run E0+8", int'(o_a), 32'hFFFC);
      if (k == 63) checkOutput("run E0+63 done", int'(done_a), 0);
      if (k == 64) begin
        checkOutput("run E0+64 o", int'(o_a), 32'h0000);
        checkOutput("run E0+64 done", int'(done_a), 1);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("done ignores start", int'(done_a), 1);

    // Hold for edges E0+2..E0+6 delays the first release to E0+9.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    idle(2);
    checkOutput("hold E0+8", int'(o_a), 32'hFFFF);
    idle(1);
    checkOutput("hold E0+9", int'(o_a), 32'hFFFE);
    idle(4);
    checkOutput("hold E0+13", int'(o_a), 32'hFFFC);

    // Relock mid-run, then restart.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(30);
    checkOutput("relock pre E0+30", int'(o_a), 32'hFF80);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("relock o", int'(o_a), 32'hFFFF);
    checkOutput("relock done", int'(done_a), 0);
    checkOutput("relock ready", int'(ready_a), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(3);
    checkOutput("restart E1+3", int'(o_a), 32'hFFFF);
    idle(1);
    checkOutput("restart E1+4", int'(o_a), 32'hFFFE);

    // Start with relock in IDLE is dropped; start during RUN is ignored.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("start+relock ready", int'(ready_a), 1);
    idle(1);
    checkOutput("start+relock stays idle", int'(ready_a), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(1);
    checkOutput("restart-ignored E0+3", int'(o_a), 32'hFFFF);
    idle(1);
    checkOutput("restart-ignored E0+4", int'(o_a), 32'hFFFE);

    // Asynchronous reset between edges.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(19);
    checkOutput("pre-reset E0+19", int'(o_a), 32'hFFF0);
    @(posedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    checkOutput("async reset o", int'(o_a), 32'hFFFF);
    checkOutput("async reset done", int'(done_a), 0);
    checkOutput("async reset ready", int'(ready_a), 1);
    @(negedge clk_i);
    reset_i = 1'b0;
    idle(1);

    // Degenerate instance: single line, one-cycle gap.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("small E0 o", int'(o_b), 1);
    checkOutput("small E0 done", int'(done_b), 0);
    idle(1);
    checkOutput("small E0+1 o", int'(o_b), 0);
    checkOutput("small E0+1 done", int'(done_b), 1);
    checkOutput("small E0+1 big o", int'(o_a), 32'hFFFF);

    // Randomized traffic checked only by the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk_i);
        #3 reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
      end else begin
        applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 199) == 0));
      end
    end

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
